// File: rtl/linreg_sweep_sched.sv
// linreg_sweep_sched: slides a fixed-length window across a stored series,
// issuing one start/si/ei job per window to a regression engine and returning
// each window's deviation and mean on a valid/ready result stream.
// Optional feature macro: LINREG_SWEEP_MIN_EN adds best_* outputs that track
// the window with the smallest deviation (earliest window wins ties).
//
// Result handshake: res_valid is raised with res_si/res_dev/res_mean/res_last
// and all of them hold steady until a cycle where res_valid && res_ready; that
// cycle transfers the result and res_valid drops on the following cycle.
module linreg_sweep_sched #(
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [DW-1:0] cfg_len,
    input  logic [DW-1:0] cfg_win,
    input  logic [DW-1:0] cfg_step,
    input  logic          go,
    output logic          busy,
    output logic          sweep_done,
    output logic          cfg_err,
    output logic          eng_start,
    output logic [DW-1:0] eng_si,
    output logic [DW-1:0] eng_ei,
    input  logic          eng_done,
    input  logic [DW-1:0] eng_dev,
    input  logic [DW-1:0] eng_mean,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_si,
    output logic [DW-1:0] res_dev,
    output logic [DW-1:0] res_mean,
    output logic          res_last,
`ifdef LINREG_SWEEP_MIN_EN
    output logic [DW-1:0] best_si,
    output logic [DW-1:0] best_dev,
    output logic [DW-1:0] best_mean,
    output logic          best_valid,
`endif
    output logic [2:0]    dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ACK   = 3'd2,
        S_RUN   = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    state_t        state_q;
    logic [DW-1:0] len_q;
    logic [DW-1:0] win_q;
    logic [DW-1:0] step_q;
    logic [DW-1:0] cur_si_q;
    logic [DW-1:0] nxt_q;
    logic          busy_q;
    logic          sweep_done_q;
    logic          cfg_err_q;
    logic          eng_start_q;
    logic [DW-1:0] eng_si_q;
    logic [DW-1:0] eng_ei_q;
    logic          res_valid_q;
    logic [DW-1:0] res_si_q;
    logic [DW-1:0] res_dev_q;
    logic [DW-1:0] res_mean_q;
    logic          res_last_q;

    logic [DW-1:0] step_eff_d;
    logic          cfg_bad_d;
    logic [DW:0]   nxt_d;
    logic          last_d;

`ifdef LINREG_SWEEP_MIN_EN
    logic [DW-1:0] best_si_q;
    logic [DW-1:0] best_dev_q;
    logic [DW-1:0] best_mean_q;
    logic          best_valid_q;
    logic          best_take_d;
`endif

    // Config screening and next-window arithmetic; the last-window test is
    // done two bits wider than DW so that a large step can never wrap.
    always_comb begin
        step_eff_d = (cfg_step == '0) ? ONE : cfg_step;
        cfg_bad_d  = (cfg_win == '0) || (cfg_win > cfg_len);
        nxt_d      = {1'b0, cur_si_q} + {1'b0, step_q};
        last_d     = ({1'b0, nxt_d} + {2'b00, win_q}) > {2'b00, len_q};
`ifdef LINREG_SWEEP_MIN_EN
        best_take_d = !best_valid_q || (eng_dev < best_dev_q);
`endif
    end

    // Sweep sequencer: state, engine job outputs and result register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            win_q        <= '0;
            step_q       <= '0;
            cur_si_q     <= '0;
            nxt_q        <= '0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            eng_start_q  <= 1'b0;
            eng_si_q     <= '0;
            eng_ei_q     <= '0;
            res_valid_q  <= 1'b0;
            res_si_q     <= '0;
            res_dev_q    <= '0;
            res_mean_q   <= '0;
            res_last_q   <= 1'b0;
`ifdef LINREG_SWEEP_MIN_EN
            best_si_q    <= '0;
            best_dev_q   <= '0;
            best_mean_q  <= '0;
            best_valid_q <= 1'b0;
`endif
        end else begin
            sweep_done_q <= 1'b0;
            eng_start_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        len_q    <= cfg_len;
                        win_q    <= cfg_win;
                        step_q   <= step_eff_d;
                        cur_si_q <= '0;
                        if (cfg_bad_d) begin
                            // Unusable config: report and finish at once.
                            cfg_err_q    <= 1'b1;
                            sweep_done_q <= 1'b1;
                        end else begin
                            cfg_err_q   <= 1'b0;
                            busy_q      <= 1'b1;
                            eng_start_q <= 1'b1;
                            eng_si_q    <= '0;
                            eng_ei_q    <= cfg_win;
                            state_q     <= S_ISSUE;
`ifdef LINREG_SWEEP_MIN_EN
                            best_si_q    <= '0;
                            best_dev_q   <= '0;
                            best_mean_q  <= '0;
                            best_valid_q <= 1'b0;
`endif
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_ACK;
                end
                S_ACK: begin
                    // The engine has taken the job once done goes low.
                    if (!eng_done) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (eng_done) begin
                        res_valid_q <= 1'b1;
                        res_si_q    <= cur_si_q;
                        res_dev_q   <= eng_dev;
                        res_mean_q  <= eng_mean;
                        res_last_q  <= last_d;
                        nxt_q       <= nxt_d[DW-1:0];
                        state_q     <= S_EMIT;
`ifdef LINREG_SWEEP_MIN_EN
                        if (best_take_d) begin
                            best_si_q    <= cur_si_q;
                            best_dev_q   <= eng_dev;
                            best_mean_q  <= eng_mean;
                            best_valid_q <= 1'b1;
                        end
`endif
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (res_last_q) begin
                            sweep_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= S_IDLE;
                        end else begin
                            // Not last, so nxt + win <= len and fits in DW.
                            cur_si_q    <= nxt_q;
                            eng_start_q <= 1'b1;
                            eng_si_q    <= nxt_q;
                            eng_ei_q    <= nxt_q + win_q;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign sweep_done  = sweep_done_q;
    assign cfg_err     = cfg_err_q;
    assign eng_start   = eng_start_q;
    assign eng_si      = eng_si_q;
    assign eng_ei      = eng_ei_q;
    assign res_valid   = res_valid_q;
    assign res_si      = res_si_q;
    assign res_dev     = res_dev_q;
    assign res_mean    = res_mean_q;
    assign res_last    = res_last_q;
    assign dbg_state_o = state_q;
`ifdef LINREG_SWEEP_MIN_EN
    assign best_si     = best_si_q;
    assign best_dev    = best_dev_q;
    assign best_mean   = best_mean_q;
    assign best_valid  = best_valid_q;
`endif

endmodule

// File: tb/tb_linreg_sweep_sched.sv
// tb_linreg_sweep_sched: bench for linreg_sweep_sched with a behavioural
// regression-engine model and a window-list reference model.
module tb_linreg_sweep_sched;
  localparam int DW = 32;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN = 3'd3;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Rst;
  logic [DW-1:0] cfg_len, cfg_win, cfg_step;
  logic          go;
  logic          busy, sweep_done, cfg_err, eng_start;
  logic [DW-1:0] eng_si, eng_ei;
  logic          eng_done;
  logic [DW-1:0] eng_dev, eng_mean;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_si, res_dev, res_mean;
  logic          res_last;
  logic [2:0]    dbg_state_o;
`ifdef LINREG_SWEEP_MIN_EN
  logic [DW-1:0] best_si, best_dev, best_mean;
  logic          best_valid;
`endif

  linreg_sweep_sched #(.DW(DW)) dut (
    .Clk(Clk), .Rst(Rst), .cfg_len(cfg_len), .cfg_win(cfg_win), .cfg_step(cfg_step),
    .go(go), .busy(busy), .sweep_done(sweep_done), .cfg_err(cfg_err),
    .eng_start(eng_start), .eng_si(eng_si), .eng_ei(eng_ei), .eng_done(eng_done),
    .eng_dev(eng_dev), .eng_mean(eng_mean), .res_valid(res_valid), .res_ready(res_ready),
    .res_si(res_si), .res_dev(res_dev), .res_mean(res_mean), .res_last(res_last),
`ifdef LINREG_SWEEP_MIN_EN
    .best_si(best_si), .best_dev(best_dev), .best_mean(best_mean), .best_valid(best_valid),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc_n = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [DW-1:0] job_si_q[$];   // windows the engine should receive, in order
  logic [DW-1:0] exp_si_q[$];   // expected result start indices
  logic          exp_last_q[$]; // expected res_last per result
  logic [DW-1:0] exp_dev_q[$];  // deviations the engine model produced
  logic [DW-1:0] exp_mean_q[$];
  logic [DW-1:0] win_m;
  bit            sweep_active = 1'b0;
  bit            err_pending = 1'b0;
  bit            done_seen;
  int            done_cyc, last_hs_cyc, result_cnt, last_res_si;
  bit            chk_zero = 1'b0;
  bit            m_best_valid = 1'b0;
  logic [DW-1:0] m_best_si, m_best_dev, m_best_mean;

  // engine model
  int            run_len = 5;
  int            cnt = 0;
  int            start_cnt = 0;
  bit            use_tab = 1'b0;
  logic [DW-1:0] dev_tab [8];
  logic [DW-1:0] pend_dev, pend_mean;

  // consumer model: 0 always ready, 1 random, 2 never ready
  int ready_mode = 0;

  // previous-cycle samples for hold checks
  logic          prev_valid, prev_ready, prev_last;
  logic [DW-1:0] prev_si, prev_dev, prev_mean, prev_eng_si, prev_eng_ei;

  task automatic clear_prev();
    prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0;
    prev_si = '0; prev_dev = '0; prev_mean = '0; prev_eng_si = '0; prev_eng_ei = '0;
  endtask

  task automatic clear_model();
    job_si_q.delete(); exp_si_q.delete(); exp_last_q.delete();
    exp_dev_q.delete(); exp_mean_q.delete();
    sweep_active = 1'b0;
    err_pending = 1'b0;
    clear_prev();
  endtask

  // Window list from the sweep rule: si = k*step for k in 0..N-1,
  // N = (len-win)/step + 1, only the final window flagged last.
  task automatic load_model(input int len, input int win, input int step, output bit bad);
    int se, n;
    se = (step == 0) ? 1 : step;
    bad = (win == 0) || (win > len);
    win_m = win;
    if (!bad) begin
      n = (len - win) / se + 1;
      for (int k = 0; k < n; k++) begin
        job_si_q.push_back(k * se);
        exp_si_q.push_back(k * se);
        exp_last_q.push_back(k == n - 1);
      end
      m_best_valid = 1'b0;
    end
  endtask

  // ---------------- monitor / scoreboard (sampled at negedge) ----------------
  task automatic monitor_step();
    logic [DW-1:0] e_si, e_dev, e_mean;
    logic          e_last;
    cyc_n++;
    if (chk_zero) begin
      chk_zero = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_sweep_done", sweep_done, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_eng_start", eng_start, 0);
      check("rst_eng_si", eng_si, 0);
      check("rst_eng_ei", eng_ei, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_si", res_si, 0);
      check("rst_res_dev", res_dev, 0);
      check("rst_res_mean", res_mean, 0);
      check("rst_res_last", res_last, 0);
      check("rst_state_idle", dbg_state_o, ST_IDLE);
`ifdef LINREG_SWEEP_MIN_EN
      check("rst_best_valid", best_valid, 0);
      check("rst_best_dev", best_dev, 0);
`endif
    end
    if (sweep_done) begin
      check("sweep_done_expected", sweep_active | err_pending, 1);
      done_seen = 1'b1;
      done_cyc = cyc_n;
      sweep_active = 1'b0;
      err_pending = 1'b0;
    end
    check("busy", busy, sweep_active);
    if (prev_valid && !prev_ready) begin
      check("res_valid_hold", res_valid, 1);
      check("res_si_hold", res_si, prev_si);
      check("res_dev_hold", res_dev, prev_dev);
      check("res_mean_hold", res_mean, prev_mean);
      check("res_last_hold", res_last, prev_last);
    end
    if (!eng_start) begin
      check("eng_si_stable", eng_si, prev_eng_si);
      check("eng_ei_stable", eng_ei, prev_eng_ei);
    end
    if (res_valid && res_ready) begin
      check("result_expected", (exp_si_q.size() != 0) && (exp_dev_q.size() != 0), 1);
      if (exp_si_q.size() != 0 && exp_dev_q.size() != 0) begin
        e_si = exp_si_q.pop_front();
        e_last = exp_last_q.pop_front();
        e_dev = exp_dev_q.pop_front();
        e_mean = exp_mean_q.pop_front();
        check("res_si", res_si, e_si);
        check("res_dev", res_dev, e_dev);
        check("res_mean", res_mean, e_mean);
        check("res_last", res_last, e_last);
        if (!m_best_valid || e_dev < m_best_dev) begin
          m_best_valid = 1'b1;
          m_best_si = e_si;
          m_best_dev = e_dev;
          m_best_mean = e_mean;
        end
      end
      result_cnt++;
      last_res_si = res_si;
      if (res_last) last_hs_cyc = cyc_n;
    end
    prev_valid = res_valid; prev_ready = res_ready; prev_last = res_last;
    prev_si = res_si; prev_dev = res_dev; prev_mean = res_mean;
    prev_eng_si = eng_si; prev_eng_ei = eng_ei;
  endtask

  // ---------------- engine model: done is a level, low while running ----------------
  task automatic engine_step();
    logic [DW-1:0] j_si;
    if (eng_start) begin
      start_cnt++;
      check("job_expected", job_si_q.size() != 0, 1);
      if (job_si_q.size() != 0) begin
        j_si = job_si_q.pop_front();
        check("eng_si", eng_si, j_si);
        check("eng_ei", eng_ei, j_si + win_m);
      end
      if (use_tab) begin
        pend_dev = dev_tab[eng_si[2:0]];
        pend_mean = eng_si + 100;
      end else begin
        pend_dev = $urandom_range(0, 50);
        pend_mean = $urandom;
      end
      exp_dev_q.push_back(pend_dev);
      exp_mean_q.push_back(pend_mean);
      eng_done = 1'b0;
      eng_dev = $urandom;
      eng_mean = $urandom;
      cnt = run_len;
    end else if (!eng_done) begin
      cnt--;
      if (cnt <= 0) begin
        eng_done = 1'b1;
        eng_dev = pend_dev;
        eng_mean = pend_mean;
      end
    end
  endtask

  // One clock: sample/model at negedge, drive inputs just after posedge.
  task automatic cyc();
    @(negedge Clk);
    monitor_step();
    engine_step();
    @(posedge Clk);
    #1;
    case (ready_mode)
      0: res_ready = 1'b1;
      1: res_ready = 1'($urandom_range(0, 1));
      default: res_ready = 1'b0;
    endcase
  endtask

  // ---------------- driver: one complete sweep ----------------
  task automatic run_sweep(input int len, input int win, input int step, input bit hold,
                           output int n_res, output int last_si, output bit err);
    bit bad;
    int go_cyc, s0;
    load_model(len, win, step, bad);
    result_cnt = 0;
    done_seen = 1'b0;
    last_hs_cyc = -100;
    last_res_si = -1;
    s0 = start_cnt;
    if (hold) ready_mode = 2;
    cfg_len = len; cfg_win = win; cfg_step = step;
    go = 1'b1;
    cyc();
    go = 1'b0;
    go_cyc = cyc_n;
    if (bad) err_pending = 1'b1;
    else sweep_active = 1'b1;
    if (hold) begin
      for (int i = 0; i < 200 && !res_valid; i++) cyc();
      check("hold_valid_seen", res_valid, 1);
      s0 = start_cnt;
      repeat (20) cyc();
      check("hold_no_second_start", start_cnt, s0);
      check("hold_valid_still", res_valid, 1);
      ready_mode = 0;
    end
    for (int i = 0; i < 3000 && !done_seen; i++) cyc();
    check("sweep_done_seen", done_seen, 1);
    if (bad) begin
      check("err_done_latency", done_cyc - go_cyc, 1);
      check("err_no_start", start_cnt, s0);
    end else begin
      check("done_after_last_hs", done_cyc - last_hs_cyc, 1);
      check("all_jobs_issued", job_si_q.size(), 0);
      check("all_results_seen", exp_si_q.size(), 0);
`ifdef LINREG_SWEEP_MIN_EN
      check("best_valid", best_valid, 1);
      check("best_si", best_si, m_best_si);
      check("best_dev", best_dev, m_best_dev);
      check("best_mean", best_mean, m_best_mean);
`endif
    end
    check("cfg_err", cfg_err, bad);
    n_res = result_cnt;
    last_si = last_res_si;
    err = cfg_err;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int len; int win; int step; int exp_n; int exp_last_si; bit exp_err;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int n, lsi, base, se, exp_n;
    bit err, ok;
    int len, win, step;

    vecs[0] = '{10, 4, 3, 3, 6, 1'b0};
    vecs[1] = '{8, 8, 0, 1, 0, 1'b0};
    vecs[2] = '{10, 0, 2, 0, 0, 1'b1};
    vecs[3] = '{10, 12, 1, 0, 0, 1'b1};
    vecs[4] = '{7, 3, 2, 3, 4, 1'b0};
    vecs[5] = '{9, 2, 10, 1, 0, 1'b0};
    vecs[6] = '{1, 1, 1, 1, 0, 1'b0};
    vecs[7] = '{20, 5, 5, 4, 15, 1'b0};

    Rst = 1'b1; go = 1'b0; cfg_len = '0; cfg_win = '0; cfg_step = '0;
    eng_done = 1'b1; eng_dev = '0; eng_mean = '0; res_ready = 1'b0;
    clear_model();
    repeat (3) cyc();
    Rst = 1'b0;
    chk_zero = 1'b1;
    cyc();

    // table-driven sweeps, engine run of 5 cycles, consumer always ready
    run_len = 5;
    ready_mode = 0;
    for (int v = 0; v < 8; v++) begin
      run_sweep(vecs[v].len, vecs[v].win, vecs[v].step, 1'b0, n, lsi, err);
      check("vec_count", n, vecs[v].exp_n);
      check("vec_err", err, vecs[v].exp_err);
      if (!vecs[v].exp_err) check("vec_last_si", lsi, vecs[v].exp_last_si);
      repeat (2) cyc();
    end

    // consumer stalls 20 cycles on the first result
    run_sweep(10, 4, 3, 1'b1, n, lsi, err);
    check("hold_count", n, 3);
    repeat (2) cyc();

    // randomized sweeps against the window-list model
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 24);
      win = $urandom_range(0, len + 1);
      step = $urandom_range(0, 6);
      run_len = $urandom_range(2, 7);
      ready_mode = 1;
      se = (step == 0) ? 1 : step;
      exp_n = (win == 0 || win > len) ? 0 : (len - win) / se + 1;
      run_sweep(len, win, step, 1'b0, n, lsi, err);
      check("rand_count", n, exp_n);
      repeat ($urandom_range(1, 3)) cyc();
    end

    // reset while the second window is running
    run_len = 5;
    ready_mode = 0;
    load_model(10, 4, 3, err);
    base = start_cnt;
    cfg_len = 10; cfg_win = 4; cfg_step = 3;
    go = 1'b1;
    cyc();
    go = 1'b0;
    sweep_active = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      cyc();
      ok = (start_cnt >= base + 2) && (dbg_state_o == ST_RUN);
    end
    check("reached_run_window2", ok, 1);
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
    clear_model();
    chk_zero = 1'b1;
    cyc();
    run_sweep(5, 5, 1, 1'b0, n, lsi, err);
    check("post_rst_count", n, 1);
    check("post_rst_last_si", lsi, 0);

`ifdef LINREG_SWEEP_MIN_EN
    // minimum-deviation tracking with a tie between windows 1 and 2
    use_tab = 1'b1;
    dev_tab[0] = 9; dev_tab[1] = 4; dev_tab[2] = 4; dev_tab[3] = 7;
    dev_tab[4] = 0; dev_tab[5] = 0; dev_tab[6] = 0; dev_tab[7] = 0;
    run_sweep(6, 3, 1, 1'b0, n, lsi, err);
    check("min_count", n, 4);
    check("min_best_si", best_si, 1);
    check("min_best_dev", best_dev, 4);
    check("min_best_mean", best_mean, 101);
    repeat (3) cyc();
    check("min_best_si_idle", best_si, 1);
    check("min_best_valid_idle", best_valid, 1);
    use_tab = 1'b0;
`endif

    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/linreg_sweep_sched.md
Name: linreg_sweep_sched

Overview:
- Sequencer that sweeps a fixed-length window across a stored time series.
- Issues one start/si/ei job per window to a single LinRegDev-style regression engine and waits for its done.
- Returns each window's deviation and mean on a valid/ready result stream.
- Sits between the top-level controller, which issues config and go, and the regression engine.

Parameters:
- DW, 32, width of index, deviation and mean values.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- cfg_len  in  DW  total sample count; valid indices are 0..cfg_len-1.
- cfg_win  in  DW  window length in samples.
- cfg_step  in  DW  window advance in samples; 0 is treated as 1.
- go  in  1  one-cycle request to start a sweep; config is sampled in the same cycle.
- busy  out  1  high from the cycle after an accepted go until the cycle sweep_done pulses.
- sweep_done  out  1  one-cycle pulse when the sweep completes.
- cfg_err  out  1  set when a go carries unusable config; cleared by the next accepted go.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_si  out  DW  window start index; held stable while a job is active.
- eng_ei  out  DW  window end index (exclusive); held stable while a job is active.
- eng_done  in  1  engine done level: high when idle, low while running.
- eng_dev  in  DW  engine deviation result.
- eng_mean  in  DW  engine mean result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_si  out  DW  start index of the window that produced the result.
- res_dev  out  DW  captured deviation.
- res_mean  out  DW  captured mean.
- res_last  out  1  marks the final result of the sweep.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal registers cleared. Rst mid-sweep abandons the sweep with no sweep_done pulse. The engine is not reset by this block.
- IDLE:
  - go=1 latches cfg_len, cfg_win and step (step=1 if cfg_step=0), and sets cur_si=0.
  - If cfg_win=0 or cfg_win>cfg_len: set cfg_err=1, pulse sweep_done next cycle, stay IDLE, busy stays 0.
  - Otherwise: clear cfg_err, go to ISSUE.
  - go is ignored in every state except IDLE.
- ISSUE (1 cycle):
  - eng_start=1, eng_si=cur_si, eng_ei=cur_si+win.
  - Next state ACK.
- ACK: wait for eng_done=0, then go to RUN.
- RUN:
  - Wait for eng_done=1.
  - On that cycle capture eng_dev/eng_mean into res_dev/res_mean, set res_si=cur_si.
  - Compute nxt=cur_si+step in DW+1 bits; res_last=1 if nxt+win > len (DW+2-bit compare, no wrap).
  - Next state EMIT.
- EMIT:
  - res_valid=1; all res_* outputs held stable until res_valid&&res_ready.
  - On the handshake cycle, res_valid drops the next cycle.
  - If res_last: pulse sweep_done and go to IDLE; busy falls together with the sweep_done pulse.
  - Otherwise set cur_si=nxt and go to ISSUE.
  - Result to next eng_start: minimum 1 idle cycle.
- Latency per window: ISSUE(1) + ACK(>=1) + engine run + RUN capture(1) + EMIT(>=1).
- Window count = floor((len-win)/step)+1. Every window is fully inside 0..len-1; a partial tail window is never issued.
- eng_si and eng_ei change only in ISSUE.
- If eng_done is already 0 when ISSUE fires, ACK exits on the first cycle it sees 0.

Optional Feature:
- Macro: LINREG_SWEEP_MIN_EN.
- Defined:
  - Extra outputs best_si[DW-1:0], best_dev[DW-1:0], best_mean[DW-1:0] and best_valid.
  - On each RUN capture, if best_valid=0 or eng_dev < best_dev (unsigned), latch si/dev/mean; ties keep the earlier window.
  - best_valid is set on the first capture.
  - On each accepted go, all best_* are cleared in the same cycle that busy rises.
  - best_* stay stable in IDLE after the sweep ends.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- len=10, win=4, step=3, engine model with 5-cycle run and res_ready=1 -> jobs (si,ei) = (0,4), (3,7), (6,10); three results, res_last only on si=6; sweep_done one cycle after the third handshake.
- len=8, win=8, step=0 -> single job (0,8) with res_last=1; step treated as 1.
- win=0, then separately win=12 with len=10 -> cfg_err=1, sweep_done pulses, eng_start never asserts, busy stays 0.
- res_ready held 0 for 20 cycles on the first result -> res_valid and res_* stable throughout; no second eng_start until the handshake.
- Rst asserted in RUN of the second window -> next cycle all outputs 0, state IDLE; a following go with len=5, win=5 runs cleanly.
- LINREG_SWEEP_MIN_EN with deviations 9, 4, 4, 7 for si = 0, 1, 2, 3 (len=6, win=3, step=1) -> best_si=1, best_dev=4 at sweep end.
